// File: rtl/alu_mdu_control.sv
// EX-stage control: ALU control decode plus an iterative multiply/divide unit owning HI/LO.
// Optional build macro MDU_ZERO_BYPASS_EN: multiplies with a zero operand skip the RUN phase.

`ifndef DEFAULT_ALU_CTR_BUS_WIDTH
  `define DEFAULT_ALU_CTR_BUS_WIDTH 4
`endif
`ifndef DEFAULT_ALU_OP_BUS_WIDTH
  `define DEFAULT_ALU_OP_BUS_WIDTH 4
`endif
`ifndef DEFAULT_ALU_FUNCT_BUS_WIDTH
  `define DEFAULT_ALU_FUNCT_BUS_WIDTH 6
`endif

`ifndef CODE_ALU_CTR_LOAD_TYPE
  `define CODE_ALU_CTR_LOAD_TYPE   4'd0
  `define CODE_ALU_CTR_STORE_TYPE  4'd1
  `define CODE_ALU_CTR_ADDI        4'd2
  `define CODE_ALU_CTR_BRANCH_TYPE 4'd3
  `define CODE_ALU_CTR_ANDI        4'd4
  `define CODE_ALU_CTR_ORI         4'd5
  `define CODE_ALU_CTR_XORI        4'd6
  `define CODE_ALU_CTR_SLTI        4'd7
  `define CODE_ALU_CTR_R_TYPE      4'd8
`endif

`ifndef CODE_ALU_EX_NOP
  `define CODE_ALU_EX_SLL  4'd0
  `define CODE_ALU_EX_SRL  4'd1
  `define CODE_ALU_EX_SRA  4'd2
  `define CODE_ALU_EX_ADD  4'd3
  `define CODE_ALU_EX_SUB  4'd4
  `define CODE_ALU_EX_AND  4'd5
  `define CODE_ALU_EX_OR   4'd6
  `define CODE_ALU_EX_XOR  4'd7
  `define CODE_ALU_EX_NOR  4'd8
  `define CODE_ALU_EX_SLT  4'd9
  `define CODE_ALU_EX_SLLV 4'd10
  `define CODE_ALU_EX_SRLV 4'd11
  `define CODE_ALU_EX_SRAV 4'd12
  `define CODE_ALU_EX_NOP  4'd15
`endif

`ifndef FUNCT_SLL
  `define FUNCT_SLL  6'h00
  `define FUNCT_SRL  6'h02
  `define FUNCT_SRA  6'h03
  `define FUNCT_SLLV 6'h04
  `define FUNCT_SRLV 6'h06
  `define FUNCT_SRAV 6'h07
  `define FUNCT_ADD  6'h20
  `define FUNCT_SUB  6'h22
  `define FUNCT_AND  6'h24
  `define FUNCT_OR   6'h25
  `define FUNCT_XOR  6'h26
  `define FUNCT_NOR  6'h27
  `define FUNCT_SLT  6'h2A
`endif

module alu_mdu_control #(
  parameter int DATA_BUS_WIDTH      = 32,
  parameter int ALU_CTR_BUS_WIDTH   = `DEFAULT_ALU_CTR_BUS_WIDTH,
  parameter int ALU_OP_BUS_WIDTH    = `DEFAULT_ALU_OP_BUS_WIDTH,
  parameter int ALU_FUNCT_BUS_WIDTH = `DEFAULT_ALU_FUNCT_BUS_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  input  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_op,
  input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
  input  logic [DATA_BUS_WIDTH-1:0]      i_rs_data,
  input  logic [DATA_BUS_WIDTH-1:0]      i_rt_data,
  output logic [ALU_CTR_BUS_WIDTH-1:0]   o_alu_ctr,
  output logic [DATA_BUS_WIDTH-1:0]      o_mdu_result,
  output logic                           o_mdu_result_valid,
  output logic                           o_stall,
  output logic                           o_div_by_zero
);

  localparam int N  = DATA_BUS_WIDTH;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_MFHI  = ALU_FUNCT_BUS_WIDTH'('h10);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_MTHI  = ALU_FUNCT_BUS_WIDTH'('h11);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_MFLO  = ALU_FUNCT_BUS_WIDTH'('h12);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_MTLO  = ALU_FUNCT_BUS_WIDTH'('h13);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_MULT  = ALU_FUNCT_BUS_WIDTH'('h18);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_MULTU = ALU_FUNCT_BUS_WIDTH'('h19);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_DIV   = ALU_FUNCT_BUS_WIDTH'('h1A);
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] F_DIVU  = ALU_FUNCT_BUS_WIDTH'('h1B);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [N-1:0]  hi, lo;
  logic [N-1:0]  p_hi, p_lo;   // mul: running product; div: remainder / quotient
  logic [N-1:0]  mag_b;        // multiplicand or divisor magnitude
  logic          op_div, neg_res, neg_rem, dbz_q;

  // ---------------- ALU control decode ----------------
  logic [ALU_CTR_BUS_WIDTH-1:0] alu_ctr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_ctr = `CODE_ALU_EX_NOP;
    case (i_alu_op)
      `CODE_ALU_CTR_LOAD_TYPE,
      `CODE_ALU_CTR_STORE_TYPE,
      `CODE_ALU_CTR_ADDI:        alu_ctr = `CODE_ALU_EX_ADD;
      `CODE_ALU_CTR_BRANCH_TYPE: alu_ctr = `CODE_ALU_EX_SUB;
      `CODE_ALU_CTR_ANDI:        alu_ctr = `CODE_ALU_EX_AND;
      `CODE_ALU_CTR_ORI:         alu_ctr = `CODE_ALU_EX_OR;
      `CODE_ALU_CTR_XORI:        alu_ctr = `CODE_ALU_EX_XOR;
      `CODE_ALU_CTR_SLTI:        alu_ctr = `CODE_ALU_EX_SLT;
      `CODE_ALU_CTR_R_TYPE: begin
        case (i_funct)
          `FUNCT_SLL:  alu_ctr = `CODE_ALU_EX_SLL;
          `FUNCT_SRL:  alu_ctr = `CODE_ALU_EX_SRL;
          `FUNCT_SRA:  alu_ctr = `CODE_ALU_EX_SRA;
          `FUNCT_SLLV: alu_ctr = `CODE_ALU_EX_SLLV;
          `FUNCT_SRLV: alu_ctr = `CODE_ALU_EX_SRLV;
          `FUNCT_SRAV: alu_ctr = `CODE_ALU_EX_SRAV;
          `FUNCT_ADD:  alu_ctr = `CODE_ALU_EX_ADD;
          `FUNCT_SUB:  alu_ctr = `CODE_ALU_EX_SUB;
          `FUNCT_AND:  alu_ctr = `CODE_ALU_EX_AND;
          `FUNCT_OR:   alu_ctr = `CODE_ALU_EX_OR;
          `FUNCT_XOR:  alu_ctr = `CODE_ALU_EX_XOR;
          `FUNCT_NOR:  alu_ctr = `CODE_ALU_EX_NOR;
          `FUNCT_SLT:  alu_ctr = `CODE_ALU_EX_SLT;
          default:     alu_ctr = `CODE_ALU_EX_NOP;
        endcase
      end
      default: alu_ctr = `CODE_ALU_EX_NOP;
    endcase
  end

  assign o_alu_ctr = alu_ctr;

  // ---------------- MDU instruction decode ----------------
  logic is_rtype, is_mul, is_div, is_signed, mdu_open, start;
  logic do_mthi, do_mtlo, do_mfhi, do_mflo, div_zero, mul_zero;
  logic rs_neg, rt_neg;
  logic [N-1:0] rs_mag, rt_mag;

  assign is_rtype  = i_valid && (i_alu_op == `CODE_ALU_CTR_R_TYPE);
  assign is_mul    = is_rtype && (i_funct == F_MULT || i_funct == F_MULTU);
  assign is_div    = is_rtype && (i_funct == F_DIV  || i_funct == F_DIVU);
  assign is_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
  assign mdu_open  = (state == ST_IDLE) || (state == ST_DONE);
  assign start     = (is_mul || is_div) && (state == ST_IDLE);

  assign do_mthi = is_rtype && mdu_open && (i_funct == F_MTHI);
  assign do_mtlo = is_rtype && mdu_open && (i_funct == F_MTLO);
  assign do_mfhi = is_rtype && mdu_open && (i_funct == F_MFHI);
  assign do_mflo = is_rtype && mdu_open && (i_funct == F_MFLO);

  assign rs_neg = is_signed && i_rs_data[N-1];
  assign rt_neg = is_signed && i_rt_data[N-1];
  assign rs_mag = rs_neg ? -i_rs_data : i_rs_data;
  assign rt_mag = rt_neg ? -i_rt_data : i_rt_data;

  assign div_zero = is_div && (i_rt_data == '0);
`ifdef MDU_ZERO_BYPASS_EN
  assign mul_zero = is_mul && ((i_rs_data == '0) || (i_rt_data == '0));
`else
  assign mul_zero = 1'b0;
`endif

  // ---------------- Datapath step and sign fix-up ----------------
  logic [N:0]     mul_sum, div_shift, div_diff;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag_b} : '0);
  assign div_shift = {p_hi, p_lo[N-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};

  assign prod     = {p_hi, p_lo};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = neg_res ? -p_lo : p_lo;
  assign rem_fix  = neg_rem ? -p_hi : p_hi;

  // NOTE: sequential state uses non-blocking assignments; the async reset clears every register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      mag_b   <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (div_zero) begin
              dbz_q <= 1'b1;
              state <= ST_DONE;
            end else if (mul_zero) begin
              p_hi    <= '0;
              p_lo    <= '0;
              op_div  <= 1'b0;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              state   <= ST_FIX;
            end else begin
              p_hi    <= '0;
              p_lo    <= rs_mag;
              mag_b   <= rt_mag;
              op_div  <= is_div;
              neg_res <= rs_neg ^ rt_neg;
              neg_rem <= rs_neg;
              count   <= CW'(N);
              state   <= ST_RUN;
            end
          end else begin
            if (do_mthi) hi <= i_rs_data;
            if (do_mtlo) lo <= i_rs_data;
          end
        end
        ST_RUN: begin
          if (op_div) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!div_diff[N]) begin
              p_hi <= div_diff[N-1:0];
              p_lo <= {p_lo[N-2:0], 1'b1};
            end else begin
              p_hi <= div_shift[N-1:0];
              p_lo <= {p_lo[N-2:0], 1'b0};
            end
          end else begin
            p_hi <= mul_sum[N:1];
            p_lo <= {mul_sum[0], p_lo[N-1:1]};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end
          state <= ST_DONE;
        end
        default: begin
          dbz_q <= 1'b0;
          if (do_mthi) hi <= i_rs_data;
          if (do_mtlo) lo <= i_rs_data;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational outputs are masked while reset is held so a presented instruction cannot leak through.
  assign o_stall            = !i_reset && (start || (state == ST_RUN) || (state == ST_FIX));
  assign o_mdu_result_valid = !i_reset && (do_mfhi || do_mflo);
  assign o_mdu_result       = !o_mdu_result_valid ? '0 : (do_mfhi ? hi : lo);
  assign o_div_by_zero      = dbz_q;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed self-checking bench for alu_mdu_control: ALU decode, MULT/DIV results, stall lengths,
// divide-by-zero, MTHI/MTLO/MFHI/MFLO and mid-operation reset.
module tb_alu_mdu_control;

  localparam int N = 32;

  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_ORI    = 4'd5;
  localparam logic [3:0] OP_R      = 4'd8;
  localparam logic [3:0] OP_UNK    = 4'd15;

  localparam logic [3:0] EX_ADD = 4'd3;
  localparam logic [3:0] EX_SUB = 4'd4;
  localparam logic [3:0] EX_OR  = 4'd6;
  localparam logic [3:0] EX_NOR = 4'd8;
  localparam logic [3:0] EX_NOP = 4'd15;

  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

`ifdef MDU_ZERO_BYPASS_EN
  localparam int ZERO_MUL_STALL = 2;
`else
  localparam int ZERO_MUL_STALL = N + 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs, rt;
  logic [3:0]  alu_ctr;
  logic [31:0] mdu_result;
  logic        mdu_result_valid, stall, div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_mdu_control #(
    .DATA_BUS_WIDTH(N),
    .ALU_CTR_BUS_WIDTH(4),
    .ALU_OP_BUS_WIDTH(4),
    .ALU_FUNCT_BUS_WIDTH(6)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_valid(valid),
    .i_alu_op(alu_op),
    .i_funct(funct),
    .i_rs_data(rs),
    .i_rt_data(rt),
    .o_alu_ctr(alu_ctr),
    .o_mdu_result(mdu_result),
    .o_mdu_result_valid(mdu_result_valid),
    .o_stall(stall),
    .o_div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic decode(input string tag, input logic [3:0] op, input logic [5:0] f,
                        input logic [3:0] exp);
    @(negedge clk);
    valid = 1'b0; alu_op = op; funct = f;
    #1 check(tag, 64'(alu_ctr), 64'(exp));
  endtask

  // Issue an MDU op and hold it while stalled; counts stall cycles and notes any div_by_zero pulse.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int stall_cyc, output bit dbz_seen);
    @(negedge clk);
    valid = 1'b1; alu_op = OP_R; funct = f; rs = a; rt = b;
    stall_cyc = 0; dbz_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (div_by_zero) dbz_seen = 1'b1;
      if (!stall) break;
      stall_cyc++;
      @(negedge clk);
    end
    check({tag, "_released"}, 64'(stall), 64'd0);
    @(posedge clk);
    #1 valid = 1'b0; funct = 6'h00;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clk);
    valid = 1'b1; alu_op = OP_R; funct = F_MFHI;
    #1 check({tag, "_hi"}, 64'(mdu_result), 64'(exp_hi));
    @(negedge clk);
    funct = F_MFLO;
    #1 check({tag, "_lo"}, 64'(mdu_result), 64'(exp_lo));
    valid = 1'b0; funct = 6'h00;
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] data);
    @(negedge clk);
    valid = 1'b1; alu_op = OP_R; funct = f; rs = data;
    @(posedge clk);
    #1 valid = 1'b0; funct = 6'h00;
  endtask

  int stall_cyc;
  bit dbz_seen;

  initial begin
    rst = 1'b1; valid = 1'b0; alu_op = OP_R; funct = 6'h00; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    // Instructions presented during reset must not stall or produce a result.
    valid = 1'b1; funct = F_MULT;
    #1 check("rst_stall", 64'(stall), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    funct = F_MFHI;
    #1 check("rst_res_valid", 64'(mdu_result_valid), 64'd0);
    check("rst_res", 64'(mdu_result), 64'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    decode("dec_rtype_sub", OP_R, F_SUB, EX_SUB);
    decode("dec_rtype_nor", OP_R, F_NOR, EX_NOR);
    decode("dec_branch", OP_BRANCH, 6'h00, EX_SUB);
    decode("dec_load", OP_LOAD, 6'h00, EX_ADD);
    decode("dec_ori", OP_ORI, 6'h00, EX_OR);
    decode("dec_mult_nop", OP_R, F_MULT, EX_NOP);
    decode("dec_unknown_op", OP_UNK, F_SUB, EX_NOP);

    // -2 * 3 = -6
    run_op("mult_neg", F_MULT, 32'hFFFF_FFFE, 32'd3, stall_cyc, dbz_seen);
    check("mult_neg_stall", 64'(stall_cyc), 64'(N + 2));
    @(negedge clk);
    valid = 1'b1; alu_op = OP_R; funct = F_MFLO;
    #1 check("mflo_valid", 64'(mdu_result_valid), 64'd1);
    check("mflo_value", 64'(mdu_result), 64'hFFFF_FFFA);
    valid = 1'b0;
    #1 check("mflo_bubble_valid", 64'(mdu_result_valid), 64'd0);
    read_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("mult_negneg", F_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, stall_cyc, dbz_seen);
    read_hilo("mult_negneg", 32'd0, 32'd15);

    run_op("multu_carry", F_MULTU, 32'hFFFF_FFFF, 32'd2, stall_cyc, dbz_seen);
    read_hilo("multu_carry", 32'd1, 32'hFFFF_FFFE);

    run_op("divu", F_DIVU, 32'd100, 32'd7, stall_cyc, dbz_seen);
    check("divu_stall", 64'(stall_cyc), 64'(N + 2));
    check("divu_no_dbz", 64'(dbz_seen), 64'd0);
    read_hilo("divu", 32'd2, 32'd14);

    run_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, stall_cyc, dbz_seen);
    read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, stall_cyc, dbz_seen);
    read_hilo("div_ovf", 32'd0, 32'h8000_0000);

    move_to(F_MTHI, 32'h0000_1234);
    move_to(F_MTLO, 32'h0000_5678);
    run_op("div_zero", F_DIV, 32'd5, 32'd0, stall_cyc, dbz_seen);
    check("div_zero_stall", 64'(stall_cyc), 64'd1);
    check("div_zero_pulse", 64'(dbz_seen), 64'd1);
    check("div_zero_pulse_end", 64'(div_by_zero), 64'd0);
    read_hilo("div_zero", 32'h0000_1234, 32'h0000_5678);

    // Reset during the tenth RUN cycle of a long multiply.
    @(negedge clk);
    valid = 1'b1; alu_op = OP_R; funct = F_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    #1 check("rst_run_start_stall", 64'(stall), 64'd1);
    repeat (10) @(posedge clk);
    #2 check("rst_run_mid_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1 check("rst_run_stall", 64'(stall), 64'd0);
    check("rst_run_dbz", 64'(div_by_zero), 64'd0);
    check("rst_run_res_valid", 64'(mdu_result_valid), 64'd0);
    check("rst_run_res", 64'(mdu_result), 64'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    read_hilo("rst_run", 32'd0, 32'd0);

    run_op("multu_small", F_MULTU, 32'd6, 32'd7, stall_cyc, dbz_seen);
    check("multu_small_stall", 64'(stall_cyc), 64'(N + 2));
    read_hilo("multu_small", 32'd0, 32'd42);

    run_op("mult_zero", F_MULT, 32'd0, 32'd5, stall_cyc, dbz_seen);
    check("mult_zero_stall", 64'(stall_cyc), 64'(ZERO_MUL_STALL));
    read_hilo("mult_zero", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu_control.md
Name: alu_mdu_control

Overview:
EX-stage control block: decodes i_alu_op/i_funct into the ALU control code, and adds a sequential multiply/divide unit (MDU).
- MDU owns the HI/LO registers and runs iterative MULT/MULTU/DIV/DIVU.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall while an operation is in flight.
- Sits beside the ALU; the EX result mux selects o_mdu_result when o_mdu_result_valid is high.

Parameters:
DATA_BUS_WIDTH, 32, operand/HI/LO width N
ALU_CTR_BUS_WIDTH, `DEFAULT_ALU_CTR_BUS_WIDTH, ALU control code width
ALU_OP_BUS_WIDTH, `DEFAULT_ALU_OP_BUS_WIDTH, alu_op width
ALU_FUNCT_BUS_WIDTH, `DEFAULT_ALU_FUNCT_BUS_WIDTH, funct width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  EX holds a real instruction (0 = bubble)
i_alu_op  in  ALU_OP_BUS_WIDTH  alu_op from control unit
i_funct  in  ALU_FUNCT_BUS_WIDTH  instruction funct field
i_rs_data  in  N  rs operand
i_rt_data  in  N  rt operand
o_alu_ctr  out  ALU_CTR_BUS_WIDTH  ALU operation code
o_mdu_result  out  N  HI (MFHI) or LO (MFLO)
o_mdu_result_valid  out  1  EX result comes from the MDU
o_stall  out  1  freeze IF/ID/EX
o_div_by_zero  out  1  one-cycle pulse on DIV/DIVU with rt==0

Behaviour:
- ALU decode (combinational) is unchanged from the current mapping.
  - R-type: SLL, SRL, SRA, ADD, SUB, AND, OR, XOR, NOR, SLT, SLLV, SRLV, SRAV map to the matching `CODE_ALU_EX_*` code.
  - Any other funct, including all MDU functs, maps to `CODE_ALU_EX_NOP`.
  - LOAD/STORE/ADDI map to ADD; BRANCH maps to SUB; ANDI/ORI/XORI/SLTI map to AND/OR/XOR/SLT; unknown alu_op maps to NOP.
- MDU functs (decoded only when alu_op = `CODE_ALU_CTR_R_TYPE` and i_valid=1):
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
- start = i_valid & R-type & funct in {MULT, MULTU, DIV, DIVU} & state==IDLE.
- FSM states IDLE, RUN, FIX, DONE:
  - IDLE -> RUN on start. Operands latch as magnitudes (signed ops: abs value); sign flags are stored; the iteration counter loads N.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter decrements; RUN -> FIX when it reaches 0 (exactly N RUN cycles).
  - FIX: apply signs and write HI/LO; FIX -> DONE.
    - Product is negated when operand signs differ.
    - Quotient is negated when signs differ; remainder takes the dividend's sign.
    - MULT*: HI = product[2N-1:N], LO = product[N-1:0].
    - DIV*: LO = quotient, HI = remainder.
  - DONE: lasts one cycle with stall low so the completed instruction leaves EX; start is suppressed in this state. DONE -> IDLE.
- o_stall = start | (state==RUN) | (state==FIX). Total stall for a MULT/DIV is N+2 cycles; stall is low in DONE.
- Divide by zero (DIV/DIVU with rt==0 at start):
  - IDLE -> DONE directly; stall lasts 1 cycle.
  - o_div_by_zero pulses in the DONE cycle.
  - HI/LO are unchanged.
- Overflow case: DIV 0x80000000 / -1 gives LO=0x80000000, HI=0 (natural wrap, no flag).
- MFHI/MFLO: o_mdu_result_valid=1 and o_mdu_result=HI/LO, combinational, when state is IDLE or DONE. Elsewhere o_mdu_result_valid=0 and o_mdu_result=0.
- MTHI/MTLO: write HI/LO from i_rs_data at the clock edge when in IDLE or DONE with i_valid=1.
- Reset (any time, including mid-RUN):
  - state=IDLE; HI=LO=0; counter and internal registers cleared.
  - o_stall=0, o_div_by_zero=0, o_mdu_result_valid=0, o_mdu_result=0.
  - Any in-flight operation is discarded.

Optional Feature:
MDU_ZERO_BYPASS_EN
- Defined: for MULT/MULTU with i_rs_data==0 or i_rt_data==0 at start, go IDLE -> FIX with a zero product; HI=LO=0 and the stall lasts 2 cycles.
- Undefined: every multiply takes the full N RUN cycles.

Test Plan:
1. ALU decode: R-type funct SUB -> `CODE_ALU_EX_SUB`; alu_op BRANCH -> SUB; funct MULT -> NOP; unknown alu_op -> NOP.
2. MULT, rs=0xFFFFFFFE, rt=3, N=32 -> o_stall high exactly 34 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; following MFLO gives o_mdu_result=0xFFFFFFFA.
3. DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI 0x1234, then DIV 5/0 -> stall 1 cycle, o_div_by_zero 1-cycle pulse, HI still 0x1234.
5. MULTU 0xFFFFFFFF×0xFFFFFFFF, assert i_reset at RUN cycle 10 -> outputs zero immediately; HI=LO=0; next MULTU 6×7 -> LO=42, HI=0.
6. MULT 0×5 -> with MDU_ZERO_BYPASS_EN stall 2 cycles; without it 34 cycles; HI=LO=0 in both cases.
